// File: rtl/line_burst_adapter.sv
// Whole-line to multi-beat burst adapter between the cache and main memory.
// A single FSM drives fixed-length, ascending-order bursts and tolerates stalled beats.
module line_burst_adapter #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int num_beats = s_line / s_burst,
  parameter int s_offset  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [s_line-1:0]  line_wdata,
  output logic [s_line-1:0]  line_rdata,
  output logic               line_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_address,
  output logic [s_burst-1:0] mem_wdata,
  input  logic [s_burst-1:0] mem_rdata,
  input  logic               mem_resp
);

  localparam int cnt_w = $clog2(num_beats);
  localparam logic [31:0] off_mask = ~((32'd1 << s_offset) - 32'd1);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                                state_r;
  logic [cnt_w-1:0]                      cnt_r;
  logic [31:0]                           addr_r;
  logic [num_beats-1:0][s_burst-1:0]     buf_r;

  // Request acceptance, beat transfer and completion sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= 32'd0;
      buf_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (line_read) begin
            addr_r  <= line_address;
            cnt_r   <= '0;
            state_r <= READ;
          end else if (line_write) begin
            addr_r  <= line_address;
            buf_r   <= line_wdata;
            cnt_r   <= '0;
            state_r <= WRITE;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (mem_resp) begin
            buf_r[cnt_r] <= mem_rdata;
            cnt_r        <= cnt_r + 1'b1;
            state_r      <= (cnt_r == last_beat) ? DONE : READ;
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (mem_resp) begin
            cnt_r   <= cnt_r + 1'b1;
            state_r <= (cnt_r == last_beat) ? DONE : WRITE;
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs depend on state alone, so reset removes them without a clock edge.
  assign mem_read    = (state_r == READ);
  assign mem_write   = (state_r == WRITE);
  assign line_resp   = (state_r == DONE);
  assign mem_address = addr_r & off_mask;
  assign mem_wdata   = buf_r[cnt_r];
  assign line_rdata  = buf_r;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: directed vector table, reset corner cases
// and randomized transactions checked against a transaction-level reference model.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_line;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    logic [31:0]  pat;
    bit           idle_resp;
    bit           exp_rd;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t tbl[5];

  line_burst_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand64(), rand64(), rand64(), rand64()};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expectations come from the transaction record; mem_wdata for each cycle
  // is the beat indexed by the number of responses already given.
  task automatic run_txn(input vec_t v, input string nm);
    int k;
    int c;
    if (v.idle_resp) begin
      for (int i = 0; i < 3; i++) begin
        mem_resp  = 1'b1;
        mem_rdata = rand64();
        step();
        chk({nm, " idle rdata"}, line_rdata, last_line);
        chk({nm, " idle mem_read"}, mem_read, 1'b0);
      end
    end
    line_read    = v.rd;
    line_write   = v.wr;
    line_address = v.addr;
    line_wdata   = v.wline;
    mem_resp     = v.idle_resp;
    mem_rdata    = rand64();
    step();
    line_address = $urandom;
    line_wdata   = rand256();
    k = 0;
    c = 0;
    while (k < 4 && c < 64) begin
      chk({nm, " mem_read"}, mem_read, v.exp_rd);
      chk({nm, " mem_write"}, mem_write, !v.exp_rd);
      chk({nm, " mem_address"}, mem_address, v.exp_addr);
      chk({nm, " busy line_resp"}, line_resp, 1'b0);
      if (!v.exp_rd) chk({nm, " mem_wdata"}, mem_wdata, v.wline[k*64 +: 64]);
      mem_resp  = (c < 32) ? v.pat[c] : 1'b1;
      mem_rdata = mem_resp ? v.rline[k*64 +: 64] : rand64();
      step();
      if (mem_resp) k++;
      c++;
    end
    if (k < 4) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: beats %0d expected 4", nm, k);
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    mem_resp   = v.idle_resp;
    mem_rdata  = rand64();
    chk({nm, " done line_resp"}, line_resp, 1'b1);
    chk({nm, " done mem_read"}, mem_read, 1'b0);
    chk({nm, " done mem_write"}, mem_write, 1'b0);
    chk({nm, " line_rdata"}, line_rdata, v.exp_line);
    step();
    chk({nm, " idle line_resp"}, line_resp, 1'b0);
    chk({nm, " idle mem_read"}, mem_read, 1'b0);
    chk({nm, " idle mem_write"}, mem_write, 1'b0);
    chk({nm, " held line_rdata"}, line_rdata, v.exp_line);
    mem_resp  = 1'b0;
    last_line = v.exp_line;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " line_resp"}, line_resp, 1'b0);
    chk({nm, " mem_read"}, mem_read, 1'b0);
    chk({nm, " mem_write"}, mem_write, 1'b0);
    chk({nm, " mem_address"}, mem_address, 32'd0);
    chk({nm, " mem_wdata"}, mem_wdata, 64'd0);
    chk({nm, " line_rdata"}, line_rdata, 256'd0);
  endtask

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_d;
    logic [255:0] line_b;
    vec_t rv;

    line_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    line_d = {{8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}, {8{8'hD0}}};
    line_b = {64'hBEEF_0003_CAFE_0003, 64'hBEEF_0002_CAFE_0002,
              64'hBEEF_0001_CAFE_0001, 64'hBEEF_0000_CAFE_0000};
    tbl[0] = '{1'b1, 1'b0, 32'h1234_567F, 256'd0, line_a, 32'hFFFF_FFFF, 1'b0,
               1'b1, 32'h1234_5660, line_a};
    tbl[1] = '{1'b0, 1'b1, 32'hABCD_0024, line_d, 256'd0, 32'h0000_0059, 1'b0,
               1'b0, 32'hABCD_0020, line_d};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_1FFF, line_d, line_b, 32'hFFFF_FFFF, 1'b0,
               1'b1, 32'h0000_1FE0, line_b};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 256'd0, line_d, 32'hFFFF_FFF5, 1'b1,
               1'b1, 32'hFFFF_FFE0, line_d};
    tbl[4] = '{1'b1, 1'b0, 32'h8000_0040, 256'd0, line_a, 32'hFFFF_FFFF, 1'b0,
               1'b1, 32'h8000_0040, line_a};

    rst          = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = 32'd0;
    line_wdata   = 256'd0;
    mem_rdata    = 64'd0;
    mem_resp     = 1'b0;
    last_line    = 256'd0;
    #3;
    chk_zero("reset");
    step();
    rst = 1'b0;
    step();
    chk_zero("post reset");

    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a read, at beat 2, asserted between clock edges.
    line_read    = 1'b1;
    line_address = 32'h0000_1040;
    step();
    mem_resp  = 1'b1;
    mem_rdata = rand64();
    step();
    mem_rdata = rand64();
    step();
    chk("midrst mem_read before", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    mem_resp  = 1'b0;
    line_read = 1'b0;
    rst       = 1'b0;
    last_line = 256'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst no line_resp", line_resp, 1'b0);
      chk("midrst idle mem_read", mem_read, 1'b0);
    end
    run_txn(tbl[4], "after reset");

    for (int i = 0; i < 40; i++) begin
      rv.rd        = $urandom_range(0, 1);
      rv.wr        = rv.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr      = $urandom;
      rv.wline     = rand256();
      rv.rline     = rand256();
      rv.pat       = $urandom;
      rv.idle_resp = $urandom_range(0, 1);
      rv.exp_rd    = rv.rd;
      rv.exp_addr  = {rv.addr[31:5], 5'd0};
      rv.exp_line  = rv.rd ? rv.rline : rv.wline;
      run_txn(rv, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Converts the whole-line requests from the cache hierarchy into fixed-length multi-beat bursts on the main-memory port, in both directions. Sits directly downstream of the cache datapath/control pair. Its cache side carries the line address, the write-back line and a single-cycle completion pulse. Its memory side carries a narrow burst bus with a per-beat response.

## Interface

Parameters:
- s_line, 256: cache line width in bits.
- s_burst, 64: memory beat width in bits. s_line must be an integer multiple of s_burst.
- num_beats, s_line/s_burst: beats per line; power of two ≥ 2.
- s_offset, 5: line offset bits. Equals log2(s_line/8).

Ports:
- clk, in, 1: clock. All state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- line_read, in, 1: cache requests a line fill. Held until line_resp.
- line_write, in, 1: cache requests a line write-back. Held until line_resp.
- line_address, in, 32: line address from the cache.
- line_wdata, in, s_line: write-back line.
- line_rdata, out, s_line: assembled fill line. Valid from the line_resp cycle; held until the next accepted request.
- line_resp, out, 1: one-cycle completion pulse.
- mem_read, out, 1: burst read request.
- mem_write, out, 1: burst write request.
- mem_address, out, 32: latched address with [s_offset-1:0] forced to 0.
- mem_wdata, out, s_burst: current write beat.
- mem_rdata, in, s_burst: current read beat.
- mem_resp, in, 1: beat handshake. High = this beat is transferred this cycle.

## Operation

- Registered state: FSM state, beat counter (log2(num_beats) bits), address register, line buffer (s_line bits).
- Reset values: state IDLE, counter 0, address register 0, buffer 0. Consequently line_resp, mem_read and mem_write are 0, and mem_address, mem_wdata and line_rdata are 0.
- IDLE:
  - If line_read is high: latch line_address, clear counter, go to READ.
  - Else if line_write is high: latch line_address, load the buffer from line_wdata, clear counter, go to WRITE.
  - line_read has priority when both are high.
  - mem_resp is ignored in IDLE.
- READ:
  - mem_read is 1.
  - On each cycle with mem_resp=1, buffer[counter*s_burst +: s_burst] ← mem_rdata, and the counter increments.
  - On the beat where counter = num_beats-1, go to DONE. The counter wraps to 0.
- WRITE:
  - mem_write is 1 and mem_wdata = buffer[counter*s_burst +: s_burst].
  - The counter increments on mem_resp.
  - The last beat goes to DONE.
- DONE:
  - line_resp is 1 for exactly one cycle; then go to IDLE.
  - mem_read and mem_write are 0.
  - mem_resp is ignored.
- Beat order is ascending: beat 0 is bits [s_burst-1:0].
- Beats need not be consecutive. Cycles with mem_resp=0 stall the counter and leave the buffer unchanged.
- line_rdata is driven directly from the buffer. After a write, it shows the written line.
- line_address and line_wdata are sampled only at acceptance. Changes while busy have no effect.
- The cache must drop its request in the cycle after line_resp. A request still high in IDLE is treated as a new request.
- Reset mid-burst: state returns to IDLE immediately (asynchronously). mem_read and mem_write drop without waiting for an edge. The partial buffer contents are zeroed and no line_resp is issued.

## Timing

- mem_read, mem_write and line_resp are decoded from state only. There is no combinational path from any input to any output.
- Best-case read, with request seen at edge 0 and mem_resp high every cycle:
  - Cycles 1–4: mem_read high, beats 0–3 transferred.
  - Cycle 5: line_resp high, line_rdata valid.
  - Cycle 6: IDLE.
- Write has identical timing. mem_wdata for beat k is valid from the cycle after the previous beat's mem_resp; for beat 0 it is valid from cycle 1.
- General latency = 1 + (cycles spent in READ/WRITE) + 1.
- Back-to-back requests: the earliest new acceptance is the IDLE cycle immediately after DONE. Turnaround is 2 cycles of idle memory port.

## Test plan

- Reset: assert rst mid-cycle. Check, without waiting for a clock edge, that all outputs are 0 and the state is IDLE.
- Consecutive-beat read:
  - Stimulus: line_read with line_address=0x1234_567F; memory returns 0x11…11, 0x22…22, 0x33…33, 0x44…44 on cycles 1–4.
  - Required: mem_address=0x1234_5660; line_resp only in cycle 5; line_rdata = {0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- Stalled write:
  - Stimulus: line_write with line_wdata = {D3,D2,D1,D0}; mem_resp pattern 1,0,0,1,1,0,1.
  - Required: mem_wdata is D0, D1, D1, D1, D2, D3, D3 in those cycles; line_resp one cycle after the final beat.
- Simultaneous request: line_read and line_write both high → READ path taken, mem_write never asserted.
- Spurious responses: mem_resp held high during IDLE and DONE → counter and buffer unchanged; the next read still fills beats 0–3 in order.
- Reset at beat 2 of a read: mem_read drops asynchronously, no line_resp. A following read completes correctly, starting at beat 0.
